// File: rtl/tmds_encoder_pipelined_if.sv
// Parallel-side bus of the TMDS encoder: shared mode, per-lane payloads and
// per-lane 10-bit symbols back towards the serialiser.
interface tmds_encoder_pipelined_if #(
  parameter int CHANNELS = 3
);
  logic [2:0]            mode;
  logic [8*CHANNELS-1:0] video_data;
  logic [4*CHANNELS-1:0] data_island_data;
  logic [2*CHANNELS-1:0] control_data;
  logic [10*CHANNELS-1:0] tmds;
  logic                  mode_error;

  modport master (
    output mode, video_data, data_island_data, control_data,
    input  tmds, mode_error
  );

  modport slave (
    input  mode, video_data, data_island_data, control_data,
    output tmds, mode_error
  );
endinterface

// File: rtl/tmds_encoder_pipelined.sv
// Multi-lane two-stage TMDS encoder. Stage 1 registers the transition-minimised
// word, its ones count and the precomputed non-video symbol; stage 2 applies
// DC balancing with a per-lane running disparity and drives the symbol.

module tmds_encoder_lane #(
  parameter int         CN           = 0,
  parameter logic [9:0] RESET_SYMBOL = 10'b1101010100
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [2:0] mode,     // live input mode (stage-1 symbol select)
  input  logic [2:0] mode_s1,  // registered mode (stage-2 behaviour)
  input  logic [7:0] video,
  input  logic [3:0] nibble,
  input  logic [1:0] ctl,
  output logic [9:0] tmds
);
  localparam logic [2:0] M_CTL = 3'd0;
  localparam logic [2:0] M_VID = 3'd1;
  localparam logic [2:0] M_VGB = 3'd2;
  localparam logic [2:0] M_DI  = 3'd3;
  localparam logic [2:0] M_IGB = 3'd4;

  localparam logic [9:0] GB_POS = 10'b1011001100;
  localparam logic [9:0] GB_NEG = 10'b0100110011;

  typedef struct packed {
    logic [8:0] qm;
    logic [3:0] n1;
    logic [9:0] sym;
  } s1_t;

  function automatic logic [9:0] terc4(input logic [3:0] n);
    logic [9:0] r;
    case (n)
      4'h0: r = 10'b1010011100;
      4'h1: r = 10'b1001100011;
      4'h2: r = 10'b1011100100;
      4'h3: r = 10'b1011100010;
      4'h4: r = 10'b0101110001;
      4'h5: r = 10'b0100011110;
      4'h6: r = 10'b0110001110;
      4'h7: r = 10'b0100111100;
      4'h8: r = 10'b1011001100;
      4'h9: r = 10'b0100111001;
      4'hA: r = 10'b0110011100;
      4'hB: r = 10'b1011000110;
      4'hC: r = 10'b1010001110;
      4'hD: r = 10'b1001110001;
      4'hE: r = 10'b0101100011;
      default: r = 10'b1011000011;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] ctl_sym(input logic [1:0] c);
    logic [9:0] r;
    case (c)
      2'b00: r = 10'b1101010100;
      2'b01: r = 10'b0010101011;
      2'b10: r = 10'b0101010100;
      default: r = 10'b1010101011;
    endcase
    return r;
  endfunction

  s1_t        s1, s1_d;
  logic [3:0] n1_d;
  logic       use_xnor, acc;

  // Stage-1 next state: transition minimisation, ones count, non-video symbol
  always_comb begin
    s1_d = '0;
    n1_d = '0;
    for (int b = 0; b < 8; b++) n1_d = n1_d + {3'b000, video[b]};
    use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !video[0]);
    acc = video[0];
    s1_d.qm[0] = acc;
    for (int b = 1; b < 8; b++) begin
      acc = use_xnor ? ~(acc ^ video[b]) : (acc ^ video[b]);
      s1_d.qm[b] = acc;
    end
    s1_d.qm[8] = ~use_xnor;
    for (int b = 0; b < 8; b++) s1_d.n1 = s1_d.n1 + {3'b000, s1_d.qm[b]};
    case (mode)
      M_VGB:   s1_d.sym = (CN == 1) ? GB_NEG : GB_POS;
      M_DI:    s1_d.sym = terc4(nibble);
      M_IGB:   s1_d.sym = (CN == 0) ? terc4({2'b11, ctl}) : GB_NEG;
      default: s1_d.sym = ctl_sym(ctl);
    endcase
  end

  // Stage-1 register; reset content is the CTL=00 control slot
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      s1.qm  <= '0;
      s1.n1  <= '0;
      s1.sym <= RESET_SYMBOL;
    end else begin
      s1 <= s1_d;
    end
  end

  logic signed [5:0] cnt, cnt_d, diff;
  logic [9:0]        tmds_d;
  logic              q8;
  logic [7:0]        qm;

  assign q8   = s1.qm[8];
  assign qm   = s1.qm[7:0];
  // N1 - N0 = 2*N1 - 8
  assign diff = $signed({1'b0, s1.n1, 1'b0}) - 6'sd8;

  // Stage-2 next state: DC balance for video, table symbol otherwise
  always_comb begin
    tmds_d = tmds;
    cnt_d  = '0;
    case (mode_s1)
      M_VID: begin
        if ((cnt == 6'sd0) || (s1.n1 == 4'd4)) begin
          tmds_d = {~q8, q8, q8 ? qm : ~qm};
          cnt_d  = q8 ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 6'sd0) && (s1.n1 > 4'd4)) ||
                     ((cnt < 6'sd0) && (s1.n1 < 4'd4))) begin
          tmds_d = {1'b1, q8, ~qm};
          cnt_d  = cnt + (q8 ? 6'sd2 : 6'sd0) - diff;
        end else begin
          tmds_d = {1'b0, q8, qm};
          cnt_d  = cnt - (q8 ? 6'sd0 : 6'sd2) + diff;
        end
      end
      M_CTL, M_VGB, M_DI, M_IGB: tmds_d = s1.sym;
      default: tmds_d = tmds;  // illegal mode: hold last symbol
    endcase
  end

  // Stage-2 register: output symbol and running disparity
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      tmds <= RESET_SYMBOL;
      cnt  <= '0;
    end else begin
      tmds <= tmds_d;
      cnt  <= cnt_d;
    end
  end
endmodule

module tmds_encoder_pipelined #(
  parameter int         CHANNELS     = 3,
  parameter logic [9:0] RESET_SYMBOL = 10'b1101010100
) (
  input  logic clk_pixel,
  input  logic reset_n,
  tmds_encoder_pipelined_if.slave bus
);
  logic [CHANNELS-1:0][7:0] vid;
  logic [CHANNELS-1:0][3:0] nib;
  logic [CHANNELS-1:0][1:0] ctl;
  logic [CHANNELS-1:0][9:0] sym;
  logic [2:0]               mode_s1;
  logic                     err_s1, mode_error_q;

  assign vid = bus.video_data;
  assign nib = bus.data_island_data;
  assign ctl = bus.control_data;
  assign bus.tmds       = sym;
  assign bus.mode_error = mode_error_q;

  // Shared stage-1 mode and illegal flag; reset parks the pipe in control mode
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      mode_s1 <= 3'd0;
      err_s1  <= 1'b0;
    end else begin
      mode_s1 <= bus.mode;
      err_s1  <= (bus.mode > 3'd4);
    end
  end

  // Illegal-mode pulse aligned with the held output slot
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) mode_error_q <= 1'b0;
    else          mode_error_q <= err_s1;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    tmds_encoder_lane #(
      .CN           (i % 3),
      .RESET_SYMBOL (RESET_SYMBOL)
    ) u_lane (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .mode      (bus.mode),
      .mode_s1   (mode_s1),
      .video     (vid[i]),
      .nibble    (nib[i]),
      .ctl       (ctl[i]),
      .tmds      (sym[i])
    );
  end
endmodule

// File: tb/tb_tmds_encoder_pipelined.sv
// Scoreboard bench: the driver pushes model expectations, the monitor pops
// and compares on every output slot two cycles after issue.
module tb_tmds_encoder_pipelined;
  localparam int         CH      = 3;
  localparam logic [9:0] RST_SYM = 10'b1101010100;

  logic clk_pixel = 1'b0;
  logic reset_n   = 1'b0;

  tmds_encoder_pipelined_if #(.CHANNELS(CH)) bus();

  tmds_encoder_pipelined #(.CHANNELS(CH), .RESET_SYMBOL(RST_SYM)) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    logic [10*CH-1:0] tmds;
    logic             err;
    int               due;
    bit               has_gold;
    logic [9:0]       gold0;
  } exp_t;

  exp_t sb[$];
  int   cyc  = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   disp[CH];
  logic [9:0] last[CH];

  logic [9:0] ctl_tab [4]   = '{10'b1101010100, 10'b0010101011,
                                10'b0101010100, 10'b1010101011};
  logic [9:0] terc_tab [16] = '{10'b1010011100, 10'b1001100011, 10'b1011100100,
                                10'b1011100010, 10'b0101110001, 10'b0100011110,
                                10'b0110001110, 10'b0100111100, 10'b1011001100,
                                10'b0100111001, 10'b0110011100, 10'b1011000110,
                                10'b1010001110, 10'b1001110001, 10'b0101100011,
                                10'b1011000011};

  always @(posedge clk_pixel) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < CH; l++) begin
      disp[l] = 0;
      last[l] = RST_SYM;
    end
  endtask

  // Reference video encoding: spec rules in integer arithmetic
  function automatic logic [9:0] ref_video(input int l, input logic [7:0] d);
    int   ones, n1, n0, q8;
    bit   xn;
    logic [7:0] q;
    logic [9:0] r;
    ones = $countones(d);
    xn   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8 = xn ? 0 : 1;
    n1 = $countones(q);
    n0 = 8 - n1;
    if (disp[l] == 0 || n1 == n0) begin
      r = {q8 ? 1'b0 : 1'b1, q8 ? 1'b1 : 1'b0, q8 ? q : ~q};
      disp[l] += q8 ? (n1 - n0) : (n0 - n1);
    end else if ((disp[l] > 0 && n1 > n0) || (disp[l] < 0 && n0 > n1)) begin
      r = {1'b1, q8 ? 1'b1 : 1'b0, ~q};
      disp[l] += 2 * q8 + n0 - n1;
    end else begin
      r = {1'b0, q8 ? 1'b1 : 1'b0, q};
      disp[l] += -2 * (1 - q8) + n1 - n0;
    end
    return r;
  endfunction

  // Drive one input slot now and push the expected output slot
  task automatic apply(input logic [2:0] m, input logic [8*CH-1:0] vd,
                       input logic [4*CH-1:0] dd, input logic [2*CH-1:0] cd,
                       input bit hg, input logic [9:0] g);
    exp_t       e;
    logic [9:0] ev;
    logic [1:0] c;
    bus.mode = m;
    bus.video_data = vd;
    bus.data_island_data = dd;
    bus.control_data = cd;
    e.due = cyc + 2;
    e.err = (m > 3'd4);
    e.has_gold = hg;
    e.gold0 = g;
    for (int l = 0; l < CH; l++) begin
      c = cd[2*l +: 2];
      if (m != 3'd1) disp[l] = 0;
      case (m)
        3'd0: ev = ctl_tab[c];
        3'd1: ev = ref_video(l, vd[8*l +: 8]);
        3'd2: ev = ((l % 3) == 1) ? 10'b0100110011 : 10'b1011001100;
        3'd3: ev = terc_tab[dd[4*l +: 4]];
        3'd4: ev = ((l % 3) == 0) ? terc_tab[{2'b11, c}] : 10'b0100110011;
        default: ev = last[l];
      endcase
      last[l] = ev;
      e.tmds[10*l +: 10] = ev;
    end
    sb.push_back(e);
  endtask

  task automatic step(input logic [2:0] m, input logic [8*CH-1:0] vd,
                      input logic [4*CH-1:0] dd, input logic [2*CH-1:0] cd,
                      input bit hg = 1'b0, input logic [9:0] g = 10'b0);
    @(posedge clk_pixel);
    #1;
    apply(m, vd, dd, cd, hg, g);
  endtask

  task automatic rand_step(input int video_pct);
    logic [2:0] m;
    int r;
    r = $urandom_range(0, 99);
    if (r < video_pct) m = 3'd1;
    else               m = 3'($urandom_range(0, 7));
    step(m, (8*CH)'($urandom), (4*CH)'($urandom), (2*CH)'($urandom));
  endtask

  // Release reset with a first input slot; the slot before it is the reset content
  task automatic release_reset(input logic [2*CH-1:0] cd, input bit hg, input logic [9:0] g);
    exp_t e;
    @(posedge clk_pixel);
    #1;
    reset_n = 1'b1;
    e.due = cyc + 1;
    e.err = 1'b0;
    e.has_gold = 1'b0;
    e.gold0 = '0;
    e.tmds = {CH{RST_SYM}};
    sb.push_back(e);
    apply(3'd0, '0, '0, cd, hg, g);
  endtask

  task automatic check_reset_state(input string tag);
    for (int l = 0; l < CH; l++) check({tag, "_lane"}, 64'(bus.tmds[10*l +: 10]), 64'(RST_SYM));
    check({tag, "_mode_error"}, 64'(bus.mode_error), 64'd0);
  endtask

  // Monitor: every output slot that has an expectation due is compared
  always @(negedge clk_pixel) begin : monitor
    exp_t e;
    if (reset_n) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("tmds", 64'(bus.tmds), 64'(e.tmds));
        check("mode_error", 64'(bus.mode_error), 64'(e.err));
        if (e.has_gold) check("lane0_golden", 64'(bus.tmds[9:0]), 64'(e.gold0));
      end
    end
  end

  initial begin
    model_reset();
    bus.mode = 3'd0;
    bus.video_data = '0;
    bus.data_island_data = '0;
    bus.control_data = '0;

    // Reset state and first-slot latency
    repeat (2) @(posedge clk_pixel);
    #1;
    check_reset_state("reset");
    release_reset(6'b000001, 1'b1, 10'b0010101011);

    // DC balance on a run of zero bytes
    step(3'd0, '0, '0, '0, 1'b1, RST_SYM);
    step(3'd1, '0, '0, '0, 1'b1, 10'b0100000000);
    step(3'd1, '0, '0, '0, 1'b1, 10'b1111111111);
    step(3'd1, '0, '0, '0, 1'b1, 10'b0100000000);
    step(3'd1, '0, '0, '0, 1'b1, 10'b1111111111);

    // XNOR path from zero disparity
    step(3'd0, '0, '0, '0);
    step(3'd1, {CH{8'hFF}}, '0, '0);
    step(3'd1, {CH{8'h5A}}, '0, '0);

    // Guard bands
    step(3'd2, '0, '0, '0, 1'b1, 10'b1011001100);
    step(3'd4, '0, '0, 6'b000010, 1'b1, 10'b0101100011);

    // TERC4 and disparity restart
    step(3'd1, '0, '0, '0, 1'b1, 10'b0100000000);
    step(3'd3, '0, {CH{4'h5}}, '0, 1'b1, 10'b0100011110);
    step(3'd1, '0, '0, '0, 1'b1, 10'b0100000000);

    // Illegal mode between control slots
    step(3'd0, '0, '0, '0, 1'b1, RST_SYM);
    step(3'd6, {CH{8'hA7}}, '0, 6'b111111, 1'b1, RST_SYM);
    step(3'd0, '0, '0, '0, 1'b1, RST_SYM);

    // Long video burst, then mixed traffic
    for (int i = 0; i < 60; i++) rand_step(100);
    for (int i = 0; i < 300; i++) rand_step(55);

    // Reset mid-video takes effect without a clock edge
    for (int i = 0; i < 5; i++) rand_step(100);
    @(posedge clk_pixel);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_reset_state("async_reset");
    model_reset();
    release_reset(6'b000000, 1'b0, 10'b0);
    for (int i = 0; i < 100; i++) rand_step(70);

    // Drain with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk_pixel);
    @(negedge clk_pixel);
    #1;
    if (sb.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain: %0d expected slots never compared, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
